// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: time-shares one SLICE_W-bit ripple slice over WORDS slices, LSB first.
// Optional macro WIDE_ADD_SEQ_SUB_EN adds a 'sub' port for X - Y - Cin with borrow-out on Cout.
module wide_add_sequencer #(
    parameter int WORDS   = 4,
    parameter int SLICE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WORDS*SLICE_W-1:0]   X,
    input  logic [WORDS*SLICE_W-1:0]   Y,
    input  logic                       Cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic                       sub,
`endif
    output logic [WORDS*SLICE_W-1:0]   S,
    output logic                       Cout,
    output logic                       done_valid,
    input  logic                       done_ready,
    output logic                       busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       x_q, x_d;
    logic [W-1:0]       y_q, y_d;
    logic [W-1:0]       s_q, s_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               done_valid_q, done_valid_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_co;
    logic               final_co;

    always_comb begin
        slice_a = x_q[idx_q*SLICE_W +: SLICE_W];
        slice_b = y_q[idx_q*SLICE_W +: SLICE_W];
`ifdef WIDE_ADD_SEQ_SUB_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
        {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, carry_q};
        final_co = slice_co;
`ifdef WIDE_ADD_SEQ_SUB_EN
        // In subtract mode the top carry is inverted to report a borrow.
        final_co = slice_co ^ sub_q;
`endif
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        s_d          = s_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        done_valid_d = done_valid_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub_d        = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    x_d     = X;
                    y_d     = Y;
                    carry_d = Cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? ~Cin : Cin;
`endif
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_co;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    idx_d        = '0;
                    cout_d       = final_co;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            s_q          <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            done_valid_q <= 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s_q          <= s_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            done_valid_q <= done_valid_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sub_q        <= sub_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign S           = s_q;
    assign Cout        = cout_q;
    assign done_valid  = done_valid_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: driver pushes model results, a monitor pops and compares.
// Subtract vectors are exercised only when WIDE_ADD_SEQ_SUB_EN is defined.
module tb_wide_add_sequencer;

    localparam int WORDS   = 4;
    localparam int SLICE_W = 8;
    localparam int W       = WORDS * SLICE_W;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Cin;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] S;
    logic         Cout;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [W:0] expq[$];
    bit         dr_rand = 1'b0;
    bit         dr_fix  = 1'b1;

    int         cyc = 0;
    int         accept_cyc = 0;
    bit         inflight;
    bit         prev_dv;
    logic [W:0] held;

    wide_add_sequencer #(
        .WORDS  (WORDS),
        .SLICE_W(SLICE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .X          (X),
        .Y          (Y),
        .Cin        (Cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub        (sub),
`endif
        .S          (S),
        .Cout       (Cout),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operands.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
        logic [W:0] r;
        if (sb) begin
            r[W-1:0] = x - y - W'(c);
            r[W]     = ({1'b0, x} < ({1'b0, y} + (W+1)'(c)));
        end else begin
            r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        end
        return r;
    endfunction

    always @(negedge clk) done_ready = dr_rand ? 1'($urandom_range(0, 1)) : dr_fix;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (start_valid && start_ready) begin
                accept_cyc <= cyc;
                inflight   <= 1'b1;
            end
            if (done_valid && done_ready) inflight <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dv = 1'b0;
        end else begin
            check("start_ready", {63'd0, start_ready}, {63'd0, !inflight});
            check("busy", {63'd0, busy}, {63'd0, inflight});
            if (done_valid && !prev_dv) begin
                check("latency", 64'(cyc - accept_cyc - 1), 64'(WORDS));
                if (expq.size() == 0) begin
                    check("unexpected_result", 64'(1), 64'(0));
                end else begin
                    held = expq.pop_front();
                    check("sum", 64'(S), 64'(held[W-1:0]));
                    check("cout", {63'd0, Cout}, {63'd0, held[W]});
                end
            end else if (done_valid && prev_dv) begin
                check("hold_sum", 64'(S), 64'(held[W-1:0]));
                check("hold_cout", {63'd0, Cout}, {63'd0, held[W]});
            end
            prev_dv = done_valid;
        end
    end

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic sb, input bit push, input int extra_valid);
        int n = 0;
        while (!start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            return;
        end
        X = x;
        Y = y;
        Cin = c;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub = sb;
`endif
        start_valid = 1'b1;
        if (push) expq.push_back(model(x, y, c, sb));
        @(negedge clk);
        if (extra_valid > 0) begin
            X = $urandom;
            Y = $urandom;
            Cin = 1'($urandom);
            repeat (extra_valid) @(negedge clk);
        end
        start_valid = 1'b0;
        X = $urandom;
        Y = $urandom;
        Cin = 1'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub = 1'($urandom);
`endif
    endtask

    task automatic drain;
        int n = 0;
        while ((expq.size() != 0 || inflight) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(expq.size()) | 64'(inflight), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        X = '0;
        Y = '0;
        Cin = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_S", 64'(S), 64'(0));
        check("rst_cout", {63'd0, Cout}, 64'(0));
        check("rst_done_valid", {63'd0, done_valid}, 64'(0));
        check("rst_start_ready", {63'd0, start_ready}, 64'(1));
        check("rst_busy", {63'd0, busy}, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 0);
        drain();
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 0);
        drain();

        // Consumer stalls three cycles with the result presented.
        dr_fix = 1'b0;
        issue(32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b1, 0);
        while (!done_valid) @(negedge clk);
        repeat (3) @(negedge clk);
        dr_fix = 1'b1;
        drain();

        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 2);
        drain();

        // Reset aborts a running operation partway through.
        issue(32'h8765_4321, 32'h1357_9BDF, 1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_S", 64'(S), 64'(0));
        check("abort_cout", {63'd0, Cout}, 64'(0));
        check("abort_done_valid", {63'd0, done_valid}, 64'(0));
        check("abort_start_ready", {63'd0, start_ready}, 64'(1));
        check("abort_busy", {63'd0, busy}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef WIDE_ADD_SEQ_SUB_EN
        issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 0);
        drain();
        issue(32'h1000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 0);
        drain();
`endif

        dr_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic sb;
            sb = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
            sb = 1'($urandom);
`endif
            issue($urandom, $urandom, 1'($urandom), sb, 1'b1, (i % 3 == 0) ? 1 : 0);
        end
        dr_rand = 1'b0;
        dr_fix = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
